// File: rtl/weight_ram_loader.sv
// Weight RAM loader: after a start pulse, accepts DEPTH words over a
// valid/ready stream and stores them in a register array. The array is
// driven continuously on data.
// Ports:
//   clk, reset        - clock; asynchronous active-high reset
//   start             - begin (or restart) a full load from word 0
//   in_data, in_valid - incoming weight word and its valid flag
//   in_ready          - combinational; high in LOAD while start is low
//   busy, load_done   - LOAD / DONE state flags
//   word_count        - words written in the current or last load
//   data              - stored weights, data[i] = word i
module weight_ram_loader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         load_done,
    output logic [$clog2(DEPTH+1)-1:0]   word_count,
    output logic [WIDTH-1:0]             data [DEPTH]
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             we_c;

    // State, address and count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    // Next-state logic and handshake
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        in_ready = 1'b0;
        we_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            S_LOAD: begin
                // start takes priority: restart and refuse the word this cycle
                in_ready = !start;
                if (start) begin
                    addr_d  = '0;
                    count_d = '0;
                end else if (in_valid) begin
                    we_c    = 1'b1;
                    count_d = count_q + CW'(1);
                    // last entry: finish without advancing past DEPTH-1
                    if (addr_q == AW'(DEPTH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Weight storage; cleared only by reset, never by a restart
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_c) begin
            mem_q[addr_q] <= in_data;
        end
    end

    assign busy       = (state_q == S_LOAD);
    assign load_done  = (state_q == S_DONE);
    assign word_count = count_q;
    assign data       = mem_q;

endmodule

// File: tb/tb_weight_ram_loader.sv
// Self-checking bench for weight_ram_loader: directed scenarios plus a
// randomized phase, all compared against a word-list reference model.
module tb_weight_ram_loader;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 64;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             busy;
    logic             load_done;
    logic [6:0]       word_count;
    logic [WIDTH-1:0] dut_data [DEPTH];

    weight_ram_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .busy       (busy),
        .load_done  (load_done),
        .word_count (word_count),
        .data       (dut_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a mode flag, the number of words accepted in this
    // load, and the memory image.
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    int               m_mode;
    int               m_words;
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               hs_seen;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            check($sformatf("%s data[%0d]", tag, i), 64'(dut_data[i]), 64'(m_mem[i]));
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, " busy"},       64'(busy),       64'(m_mode == M_LOAD));
        check({tag, " load_done"},  64'(load_done),  64'(m_mode == M_DONE));
        check({tag, " word_count"}, 64'(word_count), 64'(m_words));
    endtask

    // One clock cycle: drive inputs, check the combinational ready,
    // advance the model on the edge, then check the registered status.
    task automatic cycle(input logic st, input logic v, input logic [WIDTH-1:0] d, input string tag);
        logic exp_ready;
        start    = st;
        in_valid = v;
        in_data  = d;
        #1;
        exp_ready = (m_mode == M_LOAD) && !st;
        check({tag, " in_ready"}, 64'(in_ready), 64'(exp_ready));
        @(posedge clk);
        if (st) begin
            if (m_mode != M_IDLE || st) begin
                m_mode  = M_LOAD;
                m_words = 0;
            end
        end else if (m_mode == M_LOAD && v) begin
            m_mem[m_words] = d;
            m_words++;
            hs_seen++;
            if (m_words == int'(DEPTH)) m_mode = M_DONE;
        end
        @(negedge clk);
        check_status(tag);
    endtask

    // Asynchronous reset asserted between edges; effects checked before any edge.
    task automatic do_reset(input string tag);
        start    = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        m_mode  = M_IDLE;
        m_words = 0;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        check({tag, " in_ready"}, 64'(in_ready), 64'(0));
        check_status(tag);
        check_mem(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        hs_seen  = 0;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        do_reset("rst0");

        // No start: in_valid ignored, nothing changes
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, $urandom, "idle");
        check_mem("idle");

        // Back-to-back full load of i+1
        cycle(1'b1, 1'b0, '0, "start1");
        for (int i = 0; i < int'(DEPTH); i++) cycle(1'b0, 1'b1, WIDTH'(i + 1), "b2b");
        check_mem("b2b");

        // Writes while DONE are ignored
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'hDEAD_BEEF, "done_ign");
        check_mem("done_ign");

        // Partial reload of 0xFF then stall; tail keeps i+1
        cycle(1'b1, 1'b0, '0, "reload");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'hFF, "partial");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, $urandom, "stall");
        check_mem("partial");

        // Toggling valid: 64 handshakes over 127 cycles
        cycle(1'b1, 1'b0, '0, "start2");
        hs_seen = 0;
        for (int i = 0; i < 127; i++) begin
            if (i % 2 == 0) cycle(1'b0, 1'b1, WIDTH'(i / 2 + 1), "toggle");
            else            cycle(1'b0, 1'b0, 32'h5555_0000, "toggle");
        end
        check("toggle handshakes", 64'(hs_seen), 64'(64));
        check_mem("toggle");

        // 10 words then restart with valid high, then 64 new words
        cycle(1'b1, 1'b0, '0, "start3");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, WIDTH'(32'hA0 + i), "pre");
        cycle(1'b1, 1'b1, 32'h1234_5678, "restart");
        check_mem("restart");
        for (int i = 0; i < int'(DEPTH); i++) cycle(1'b0, 1'b1, WIDTH'(32'hB0 + i), "post");
        check_mem("post");

        // Reset in the middle of a load
        cycle(1'b1, 1'b0, '0, "start4");
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, $urandom, "mid");
        do_reset("rst_mid");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, $urandom, "post_rst");
        check_mem("post_rst");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), $urandom, "rand");
            if (i % 100 == 99) check_mem("rand");
        end
        check_mem("rand_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_ram_loader.md
WEIGHT_RAM_LOADER -- requirements
Module: weight_ram_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit width of one weight word.
REQ-002 SHALL have parameter DEPTH, default 64, number of weight words (node inputs) held.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a full load from word 0.
REQ-006 SHALL have port in_data  input  WIDTH  incoming weight word.
REQ-007 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-009 SHALL have port busy  output  1  high while in LOAD state.
REQ-010 SHALL have port load_done  output  1  high while in DONE state; all DEPTH words written.
REQ-011 SHALL have port word_count  output  $clog2(DEPTH+1)  words written in the current or last load.
REQ-012 SHALL have port data  output  WIDTH x [DEPTH] unpacked array  stored weights; data[i] = word i.

Function
REQ-013 SHALL implement an FSM with states IDLE, LOAD, DONE.
REQ-014 IDLE: in_ready=0; start=1 -> LOAD with write address and word_count cleared to 0 on the same edge.
REQ-015 LOAD: in_ready = !start (combinational); busy=1.
REQ-016 Handshake SHALL occur on a cycle where in_valid && in_ready; only then is in_data written.
REQ-017 On a handshake SHALL write in_data to data[addr], increment addr and word_count; data reflects the write from the next cycle.
REQ-018 When a handshake occurs with addr == DEPTH-1, SHALL go to DONE on that edge; word_count = DEPTH.
REQ-019 Stalls (in_valid=0 in LOAD) SHALL hold addr, word_count, and memory unchanged; no timeout.
REQ-020 start=1 during LOAD SHALL abort and restart: addr and word_count -> 0, state stays LOAD, no write that cycle (in_ready=0 guarantees no word is lost by sender).
REQ-021 DONE: in_ready=0, load_done=1; start=1 -> LOAD (reload) with addr and word_count -> 0.
REQ-022 Reload/restart SHALL NOT clear memory; entries keep prior values until overwritten.
REQ-023 in_valid while in IDLE or DONE SHALL be ignored (in_ready=0, no write).
REQ-024 Write address SHALL never exceed DEPTH-1; no wrap-around write past the last entry.
REQ-025 data SHALL be driven continuously from storage (no read latency, no read port).

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, addr=0, word_count=0, in_ready=0, busy=0, load_done=0, all data[i]=0.
REQ-027 reset asserted mid-LOAD SHALL discard the partial load (memory zeroed); a new start is required afterward.
REQ-028 After reset release, no state change SHALL occur until start=1 is sampled.

Verification
REQ-029 Reset, pulse start, stream 64 words value i+1 back-to-back with in_valid=1 -> in_ready high 64 cycles, load_done=1 the cycle after word 63, word_count=64, data[i]=i+1.
REQ-030 Same load with in_valid toggling 1/0 every cycle -> 64 handshakes over 127 cycles, identical data contents, word_count steps only on handshakes.
REQ-031 Load 10 words (0xA0..0xA9), then start with in_valid=1 -> no write that cycle, word_count=0, next 64 words 0xB0.. overwrite data[0..63], load_done=1.
REQ-032 After DONE, drive in_valid=1 with 0xDEADBEEF for 5 cycles -> in_ready=0, data unchanged, load_done stays 1.
REQ-033 Assert reset after 20 words of a load -> busy=0, word_count=0, data[0..19]=0 asynchronously, in_ready=0 until next start.
REQ-034 Reload after full load of i+1, write only words 0..4 as 0xFF then stall -> data[0..4]=0xFF, data[5..63] still i+1, busy=1.
